i2c_target: RTL

- I2C target (slave) that answers the existing i2c_master on the same open-drain SCL/SDA pair.
- Holds a small byte register file addressed through an internal pointer.
- Write transaction: first data byte after the address sets the pointer; each following byte is stored at the pointer, which then auto-increments.
- Read transaction: returns bytes from the pointer with auto-increment. This lets the master's write-then-read sequence close the loop in simulation and on board.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_bus_monitor.sv | 72 +++++++
 rtl/i2c_target.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } i2c_target_state_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA and derives edge and START/STOP events.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter per line.
module i2c_bus_monitor
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_l, sda_l, scl_d, sda_d;

  // Reset to the idle-bus level so leaving reset creates no false events.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;
  logic       scl_f, sda_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
      scl_f    <= maj3(scl_hist);
      sda_f    <= maj3(sda_hist);
    end
  end

  assign scl_l = scl_f;
  assign sda_l = sda_f;
`else
  assign scl_l = scl_sync[1];
  assign sda_l = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_l;
      sda_d <= sda_l;
    end
  end

  assign scl_rise  = scl_l & ~scl_d;
  assign scl_fall  = ~scl_l & scl_d;
  assign start_det = scl_l & scl_d & sda_d & ~sda_l;
  assign stop_det  = scl_l & scl_d & ~sda_d & sda_l;
  assign sda_s     = sda_l;

endmodule

// File: rtl/i2c_target.sv
// I2C target with a pointer-addressed byte register file (write sets pointer, data auto-increments).
// Optional input glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'b0010000,
  parameter int         DEPTH       = 16,
  localparam int        PTR_W       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [3:0]       dbg_state
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_target_state_e state;
  logic [7:0]       regs [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [7:0]       shift;
  logic [7:0]       rx_byte;
  logic [2:0]       bit_cnt;
  logic             rw;

  assign rx_byte   = {shift[6:0], sda_s};
  assign rd_ptr    = ptr;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_ptr    <= '0;
      wr_data   <= '0;
      ptr       <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      rw        <= RW_WRITE;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == TARGET_ADDR) begin
                busy  <= 1'b1;
                rw    <= rx_byte[0];
                state <= ST_ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= ST_WAIT_STOP;
              end
            end
          end
          ST_PTR: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr   <= rx_byte[PTR_W-1:0];
              state <= ST_PTR_ACK;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              regs[ptr] <= rx_byte;
              wr_strobe <= 1'b1;
              wr_ptr    <= ptr;
              wr_data   <= rx_byte;
              ptr       <= ptr + PTR_W'(1);
              state     <= ST_WDATA_ACK;
            end
          end
          // ACK states see two SCL falls: the first starts driving ACK, the second ends it.
          ST_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              bit_cnt <= '0;
              case (rw)
                RW_WRITE: begin
                  sda_oe <= 1'b0;
                  state  <= ST_PTR;
                end
                RW_READ: begin
                  shift  <= regs[ptr];
                  sda_oe <= ~regs[ptr][7];
                  state  <= ST_RDATA;
                end
              endcase
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              state  <= ST_WDATA;
            end
          end
          // bit_cnt wraps to 0 after the 8th rise, marking the byte as fully sent.
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= ST_RDATA_ACK;
              end else begin
                shift  <= {shift[6:0], 1'b0};
                sda_oe <= ~shift[6];
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              case (sda_s)
                ACK:  ptr <= ptr + PTR_W'(1);
                NACK: begin
                  busy  <= 1'b0;
                  state <= ST_WAIT_STOP;
                end
              endcase
            end else if (scl_fall) begin
              shift  <= regs[ptr];
              sda_oe <= ~regs[ptr][7];
              state  <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
